yield_collector: RTL
====================

Name: yield_collector

Overview:
- Consumer end of the generator yield interface.
- Launches a generated generator module with a one-cycle `_start` pulse, then captures each yielded (`_out0`, `_out1`) tuple into an internal show-ahead FIFO until the generator raises `_done`.
- Drains the FIFO to downstream logic (pixel writer, testbench scoreboard) over a valid/ready read port.
- Provides the sequencing and buffering the generator itself lacks: start control, stale-done masking, capture, overflow detection.

Parameters:
- WIDTH, 32, bit width of each signed tuple element; matches the generator `_outN` width.
- DEPTH, 16, FIFO entries; must be a power of two, minimum 2.

Ports:
- `_clock` input 1: sole clock, rising edge.
- `_reset_n` input 1: asynchronous active-low reset.
- `run` input 1: request a new generator run; sampled only in IDLE.
- `gen_start` output 1: drives generator `_start`.
- `gen_valid` input 1: generator tuple on `gen_out0`/`gen_out1` is valid this cycle.
- `gen_out0` input WIDTH signed: generator `_out0`.
- `gen_out1` input WIDTH signed: generator `_out1`.
- `gen_done` input 1: generator `_done`.
- `rd_valid` output 1: FIFO head available.
- `rd_ready` input 1: downstream accepts head.
- `rd_data0` output WIDTH signed: head element 0.
- `rd_data1` output WIDTH signed: head element 1.
- `count` output $clog2(DEPTH)+1: current FIFO occupancy.
- `busy` output 1: run in progress.
- `complete` output 1: sticky; the last run finished via `gen_done`.
- `overflow` output 1: sticky; at least one tuple was dropped because the FIFO was full.

Behaviour:
- Reset (async assert, sync release): state=IDLE, `gen_start`=0, FIFO empty, `count`=0, `rd_valid`=0, `rd_data0`/`rd_data1`=0, `busy`=0, `complete`=0, `overflow`=0.
- FSM states: IDLE, START, SETTLE, COLLECT.
- IDLE:
  - `run`=1 -> START next cycle.
  - On that same edge: flush FIFO (`count`=0), clear `complete` and `overflow`.
  - `run` is ignored in all other states.
- START:
  - `gen_start`=1 for exactly this one cycle; `busy`=1.
  - Next state SETTLE.
- SETTLE:
  - One cycle; `busy`=1.
  - `gen_done` and `gen_valid` are ignored here, because generator `_done` may still hold its stale value from the previous run for one cycle after `_start`.
  - Next state COLLECT.
- COLLECT (`busy`=1):
  - `gen_valid`=1 pushes {`gen_out0`, `gen_out1`}.
  - `gen_done`=1 -> IDLE, `complete` set.
  - If `gen_valid` and `gen_done` are both high in the same cycle, the tuple is still pushed.
- FIFO:
  - Show-ahead: `rd_valid` = (`count` != 0); `rd_data0`/`rd_data1` reflect the head combinationally from storage.
  - Pop on `rd_valid` && `rd_ready`.
  - Reads are permitted in every state, including during collection.
- Push when full without a same-cycle pop: tuple dropped, `overflow` set, `count` stays DEPTH.
- Push and pop in the same cycle:
  - Both take effect; `count` unchanged.
  - This holds when full: the pop frees a slot and the push is accepted, `overflow` not set.
  - This holds when empty with push only: data becomes visible next cycle; there is no bypass.
- Pointers: `log2(DEPTH)` bits, wrapping naturally; full/empty derived from `count`.
- Data is stored bit-exact; no sign or width conversion.
- Reset asserted mid-run: everything returns to reset values immediately, and FIFO contents are lost. The generator is not reset by this block; the next `run` re-launches it via `gen_start`.
- `gen_done` high in IDLE is ignored.
- Latency:
  - `run` -> `gen_start`: 1 cycle.
  - `gen_valid` -> `rd_valid`: 1 cycle.
  - `gen_done` -> `busy`=0 / `complete`=1: 1 cycle.

Test Plan:
1. Basic run: pulse `run`; generator model yields (3,4) then (5,6), then `done` -> `gen_start` high for one cycle; with `rd_ready`=1, reads return (3,4) then (5,6); `complete`=1, `overflow`=0, `count` ends 0.
2. Stale done: hold `gen_done`=1 before `run`, drop it the cycle after `gen_start`, then yield (1,2) -> FSM must not exit in SETTLE; (1,2) captured; `complete` set only on the later `gen_done`.
3. Overflow: DEPTH=4, `rd_ready`=0, yield 6 tuples (i,i+10) for i=0..5 -> `count`=4, `overflow`=1, reads return i=0..3 only.
4. Full plus simultaneous pop: FIFO full, `rd_ready`=1 while yielding (7,8) -> `count` stays 4, `overflow`=0, (7,8) is read last.
5. Signed/data fidelity: yield (-1, -2147483648) -> `rd_data0`=32'hFFFFFFFF, `rd_data1`=32'h80000000; push with `gen_done` in the same cycle is captured.
6. Reset mid-COLLECT after 2 tuples -> `count`=0, `busy`=0, `rd_valid`=0 immediately; a subsequent `run` produces a fresh `gen_start` and a normal capture.

Source files
------------

// File: rtl/yield_collector.sv
// Consumer end of a generator yield interface: launches the generator, masks its
// stale done, captures yielded tuples into a show-ahead FIFO and drains them downstream.
module yield_collector #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                        _clock,
    input  logic                        _reset_n,
    input  logic                        run,
    output logic                        gen_start,
    input  logic                        gen_valid,
    input  logic signed [WIDTH-1:0]     gen_out0,
    input  logic signed [WIDTH-1:0]     gen_out1,
    input  logic                        gen_done,
    output logic                        rd_valid,
    input  logic                        rd_ready,
    output logic signed [WIDTH-1:0]     rd_data0,
    output logic signed [WIDTH-1:0]     rd_data1,
    output logic [$clog2(DEPTH):0]      count,
    output logic                        busy,
    output logic                        complete,
    output logic                        overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE,
        START,
        SETTLE,
        COLLECT
    } state_t;

    state_t state;
    state_t state_next;

    logic launch;
    logic collecting;
    logic finish;
    logic push;
    logic pop;
    logic full;
    logic accept;
    logic drop;

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    logic signed [WIDTH-1:0] mem0 [DEPTH];
    logic signed [WIDTH-1:0] mem1 [DEPTH];

    always_ff @(posedge _clock or negedge _reset_n) begin
        if (!_reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // SETTLE exists only to ignore the generator's done/valid, which may still be
    // stale from the previous run for one cycle after the start pulse.
    always_comb begin
        state_next = state;
        gen_start  = 1'b0;
        busy       = 1'b1;
        launch     = 1'b0;
        collecting = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (run) begin
                    launch     = 1'b1;
                    state_next = START;
                end
            end
            START: begin
                gen_start  = 1'b1;
                state_next = SETTLE;
            end
            SETTLE: begin
                state_next = COLLECT;
            end
            COLLECT: begin
                collecting = 1'b1;
                if (gen_done) begin
                    finish     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign full     = (count == CNT_W'(DEPTH));
    assign rd_valid = (count != '0);
    assign pop      = rd_valid && rd_ready;
    assign push     = collecting && gen_valid;
    // A same-cycle pop frees the slot, so a push into a full FIFO still lands.
    assign accept   = push && (!full || pop);
    assign drop     = push && full && !pop;

    always_ff @(posedge _clock or negedge _reset_n) begin
        if (!_reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (launch) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({accept, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge _clock or negedge _reset_n) begin
        if (!_reset_n) begin
            complete <= 1'b0;
            overflow <= 1'b0;
        end else if (launch) begin
            complete <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (finish) begin
                complete <= 1'b1;
            end
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    // Storage is data only and carries no reset; the head is masked while empty.
    always_ff @(posedge _clock) begin
        if (accept) begin
            mem0[wr_ptr] <= gen_out0;
            mem1[wr_ptr] <= gen_out1;
        end
    end

    assign rd_data0 = rd_valid ? mem0[rd_ptr] : '0;
    assign rd_data1 = rd_valid ? mem1[rd_ptr] : '0;

endmodule
